parity_stream_classifier: RTL and testbench
===========================================

// Module: parity_stream_classifier
// PURPOSE
// - Streaming parity stage that sits directly downstream of the even-number checker.
// - Accepts 32-bit numbers over a valid/ready handshake and tags each one even or odd (LSB test).
// - Forwards every number with its tag through a 2-entry skid buffer, so in_ready is registered.
// - Keeps saturating counts of even and odd numbers accepted since reset or clear.
// PARAMETERS
// - DATA_W   32  width of the number stream
// - CNT_W    16  width of even_cnt / odd_cnt
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous active-low reset
// - clear        in   1       synchronous clear of both counters
// - in_valid     in   1       upstream number valid
// - in_ready     out  1       stage can accept (registered)
// - in_data      in   DATA_W  number to classify
// - out_valid    out  1       classified number available
// - out_ready    in   1       downstream accepts
// - out_data     out  DATA_W  number, unchanged
// - out_is_even  out  1       1 = even (in_data[0]==0), 0 = odd
// - even_cnt     out  CNT_W   accepted even numbers, saturating
// - odd_cnt      out  CNT_W   accepted odd numbers, saturating
// BEHAVIOUR
// - Reset (rst_n low, async): FSM=EMPTY, in_ready=0 while rst_n low and 1 after release,
//   out_valid=0, out_data=0, out_is_even=0, even_cnt=0, odd_cnt=0.
// - Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
// - in_data must be held stable while in_valid=1 and in_ready=0.
// - FSM over buffered entries: EMPTY(0), ONE(1), FULL(2).
//   EMPTY: accept -> ONE.
//   ONE: accept & !emit -> FULL; !accept & emit -> EMPTY; both or neither -> ONE.
//   FULL: emit -> ONE (no accept possible).
// - in_ready = (state != FULL), registered. Never depends combinationally on out_ready.
// - out_valid = (state != EMPTY); out_data/out_is_even come from the head register.
// - Latency: accepted on edge N, visible on out_* after edge N (1 cycle). Zero bubbles at full rate.
// - Order is preserved; the head entry must not change while out_valid=1 and out_ready=0.
// - Tag is computed on accept as ~in_data[0] and stored with the data.
// - Counters:
//   accept of even -> even_cnt+1; accept of odd -> odd_cnt+1.
//   Each counter holds at 2^CNT_W-1 (no wrap).
// - clear=1 zeros both counters. clear with accept in the same cycle: counters are zeroed,
//   then the accepted number counts, giving 1 in its class and 0 in the other.
// - clear has no effect on buffer contents or the handshake.
// - Reset mid-stream discards all buffered entries immediately.
// CONFIGURATION
// - PARITY_DISPLAY_EN defined:
//   on each accept, $display("The number is a even number",num) or
//   $display("The number is a odd number",num), printed from the clocked block (simulation only).
// - PARITY_DISPLAY_EN undefined: no $display. Functional behaviour is identical.
// TESTING
// - Reset: rst_n=0 for 3 cycles -> out_valid=0, in_ready=0, counts 0.
//   Release rst_n -> in_ready=1 on the next edge.
// - Stream 10,7,4,0 with out_ready=1 every cycle -> out_data 10,7,4,0 with is_even 1,0,1,1,
//   one value per cycle, 1-cycle latency; then even_cnt=3, odd_cnt=1.
// - Backpressure: out_ready=0 and send 6,9 -> FULL, in_ready=0, out_data holds 6.
//   Raise out_ready -> 6 then 9 emitted in order, no loss or duplicate.
// - Saturation: CNT_W=4, send 20 even numbers -> even_cnt stays 15, odd_cnt=0.
// - Clear collision: even_cnt=5, assert clear while accepting 3 -> even_cnt=0, odd_cnt=1 next cycle.
// - Mid-stream reset: FULL with 2 entries, pulse rst_n low -> out_valid=0 at once.
//   After release, a new value of 8 passes through alone.

Source files
------------

// File: rtl/parity_stream_classifier.sv
// Even/odd tagging stage behind a 2-entry skid buffer with registered in_ready and saturating class counters.
// Define PARITY_DISPLAY_EN to print each accepted number's class during simulation.
module parity_stream_classifier #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_even,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  odd_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              accept, emit;
  logic              load_head_in, load_head_tail, load_tail;
  logic [DATA_W-1:0] tail_data;
  logic              tail_is_even;
  logic              in_is_even;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Clear zeroes first, so a same-cycle accept still lands as a count of 1.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                               input logic clr, input logic hit);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : c;
    return hit ? sat_inc(base) : base;
  endfunction

  assign accept     = in_valid & in_ready;
  assign emit       = out_valid & out_ready;
  assign out_valid  = (state != EMPTY);
  assign in_is_even = ~in_data[0];

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          state_nxt = FULL;
          load_tail = 1'b1;
        end else if (!accept && emit) begin
          state_nxt = EMPTY;
        end else if (accept && emit) begin
          load_head_in = 1'b1;
        end
      end
      FULL: begin
        if (emit) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Control: state, registered ready and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      even_cnt <= '0;
      odd_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      even_cnt <= cnt_next(even_cnt, clear, accept & in_is_even);
      odd_cnt  <= cnt_next(odd_cnt, clear, accept & ~in_is_even);
`ifdef PARITY_DISPLAY_EN
      if (accept) begin
        if (in_is_even) $display("The number is a even number", in_data);
        else            $display("The number is a odd number", in_data);
      end
`endif
    end
  end

  // Data: head drives the outputs, tail catches the skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_is_even  <= 1'b0;
      tail_data    <= '0;
      tail_is_even <= 1'b0;
    end else begin
      if (load_head_in) begin
        out_data    <= in_data;
        out_is_even <= in_is_even;
      end else if (load_head_tail) begin
        out_data    <= tail_data;
        out_is_even <= tail_is_even;
      end
      if (load_tail) begin
        tail_data    <= in_data;
        tail_is_even <= in_is_even;
      end
    end
  end

endmodule

// File: tb/tb_parity_stream_classifier.sv
// Directed vector bench for parity_stream_classifier (CNT_W=4 so saturation is reachable).
module tb_parity_stream_classifier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_is_even;
  logic [3:0]  even_cnt;
  logic [3:0]  odd_cnt;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  parity_stream_classifier #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_even(out_is_even), .even_cnt(even_cnt), .odd_cnt(odd_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        clr;
    logic        eov;
    logic [31:0] eod;
    logic        eev;
    logic        eir;
    logic [3:0]  ee;
    logic [3:0]  eo;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic clr, input logic eov, input logic [31:0] eod,
                              input logic eev, input logic eir, input logic [3:0] ee,
                              input logic [3:0] eo);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
    v.eov = eov; v.eod = eod; v.eev = eev; v.eir = eir; v.ee = ee; v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic clr);
    in_valid = iv; in_data = d; out_ready = ordy; clear = clr;
  endtask

  initial begin
    // stream 10,7,4,0 at full rate
    vecs[0]  = mk(1, 10, 1, 0, 1, 10, 1, 1, 1, 0);
    vecs[1]  = mk(1,  7, 1, 0, 1,  7, 0, 1, 1, 1);
    vecs[2]  = mk(1,  4, 1, 0, 1,  4, 1, 1, 2, 1);
    vecs[3]  = mk(1,  0, 1, 0, 1,  0, 1, 1, 3, 1);
    vecs[4]  = mk(0,  0, 1, 0, 0,  0, 0, 1, 3, 1);
    // clear, then backpressure 6,9 into FULL and drain
    vecs[5]  = mk(0,  0, 0, 1, 0,  0, 0, 1, 0, 0);
    vecs[6]  = mk(1,  6, 0, 0, 1,  6, 1, 1, 1, 0);
    vecs[7]  = mk(1,  9, 0, 0, 1,  6, 1, 0, 1, 1);
    vecs[8]  = mk(0,  0, 0, 0, 1,  6, 1, 0, 1, 1);
    vecs[9]  = mk(0,  0, 1, 0, 1,  9, 0, 1, 1, 1);
    vecs[10] = mk(0,  0, 1, 0, 0,  0, 0, 1, 1, 1);
    // build even_cnt=5, then clear colliding with accept of 3
    vecs[11] = mk(0,  0, 1, 1, 0,  0, 0, 1, 0, 0);
    vecs[12] = mk(1,  2, 1, 0, 1,  2, 1, 1, 1, 0);
    vecs[13] = mk(1,  4, 1, 0, 1,  4, 1, 1, 2, 0);
    vecs[14] = mk(1,  6, 1, 0, 1,  6, 1, 1, 3, 0);
    vecs[15] = mk(1,  8, 1, 0, 1,  8, 1, 1, 4, 0);
    vecs[16] = mk(1, 12, 1, 0, 1, 12, 1, 1, 5, 0);
    vecs[17] = mk(1,  3, 1, 1, 1,  3, 0, 1, 0, 1);
    vecs[18] = mk(0,  0, 1, 0, 0,  0, 0, 1, 0, 1);
    // FULL with upstream offering while in_ready=0, then simultaneous accept/emit
    vecs[19] = mk(1, 20, 0, 0, 1, 20, 1, 1, 1, 1);
    vecs[20] = mk(1, 21, 0, 0, 1, 20, 1, 0, 1, 2);
    vecs[21] = mk(1, 22, 1, 0, 1, 21, 0, 1, 1, 2);
    vecs[22] = mk(1, 22, 1, 0, 1, 22, 1, 1, 2, 2);
    vecs[23] = mk(0,  0, 1, 0, 0,  0, 0, 1, 2, 2);

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready",  32'(in_ready), 0);
    check("rst_out_data",  out_data, 0);
    check("rst_even_cnt",  32'(even_cnt), 0);
    check("rst_odd_cnt",   32'(odd_cnt), 0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready",  32'(in_ready), 1);
    check("rel_out_valid", 32'(out_valid), 0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].clr);
      step();
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
      if (vecs[i].eov) begin
        check($sformatf("v%0d_out_data", i), out_data, vecs[i].eod);
        check($sformatf("v%0d_is_even", i), 32'(out_is_even), 32'(vecs[i].eev));
      end
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
      check($sformatf("v%0d_even_cnt", i), 32'(even_cnt), 32'(vecs[i].ee));
      check($sformatf("v%0d_odd_cnt", i), 32'(odd_cnt), 32'(vecs[i].eo));
    end

    // saturation: 20 evens into a 4-bit counter
    drive(0, 0, 1, 1);
    step();
    for (int k = 1; k <= 20; k++) begin
      drive(1, 32'(2 * k), 1, 0);
      step();
      check($sformatf("sat%0d_even_cnt", k), 32'(even_cnt), (k > 15) ? 15 : k);
    end
    check("sat_odd_cnt", 32'(odd_cnt), 0);
    drive(0, 0, 1, 0);
    step();

    // mid-stream reset with two entries buffered
    drive(1, 30, 0, 0);
    step();
    drive(1, 31, 0, 0);
    step();
    check("mr_full_in_ready", 32'(in_ready), 0);
    check("mr_full_out_data", out_data, 30);
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("mr_async_out_valid", 32'(out_valid), 0);
    check("mr_async_in_ready",  32'(in_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_rel_in_ready",  32'(in_ready), 1);
    check("mr_rel_out_valid", 32'(out_valid), 0);
    drive(1, 8, 1, 0);
    step();
    check("mr_8_out_valid", 32'(out_valid), 1);
    check("mr_8_out_data",  out_data, 8);
    check("mr_8_is_even",   32'(out_is_even), 1);
    check("mr_8_even_cnt",  32'(even_cnt), 1);
    drive(0, 0, 1, 0);
    step();
    check("mr_after_out_valid", 32'(out_valid), 0);
    check("mr_after_odd_cnt",   32'(odd_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
